moore_1010_seq_det_over: RTL and testbench

- Moore finite-state machine that detects the serial bit pattern 1010 on a single-bit input, one bit per clock.
- Overlapping detection: the trailing "10" of a match is reused as the start of the next match.
- The detect flag depends only on the current state.
- Current and next state are exported for debug/observation. The block is a standalone leaf used as a serial pattern detector.

---
 rtl/moore_1010_seq_det_over.sv | 68 ++++++
 tb/tb_moore_1010_seq_det_over.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/moore_1010_seq_det_over.sv
// rtl/moore_1010_seq_det_over.sv - Moore detector for serial pattern 1010 with overlap
// Optional match counter det_cnt is compiled in when MOORE_DET_CNT_EN is defined.
module moore_1010_seq_det_over
`ifdef MOORE_DET_CNT_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In,
    output logic             OP,
    output logic [2:0]       CS,
    output logic [2:0]       NS
`ifdef MOORE_DET_CNT_EN
    ,
    output logic [CNT_W-1:0] det_cnt
`endif
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    // S4 on a 1 falls back to S3: the trailing "10" of the match starts the next one.
    always_comb begin
        state_nxt = S0;
        case (state)
            S0:      state_nxt = In ? S1 : S0;
            S1:      state_nxt = In ? S1 : S2;
            S2:      state_nxt = In ? S3 : S0;
            S3:      state_nxt = In ? S1 : S4;
            S4:      state_nxt = In ? S3 : S0;
            default: state_nxt = S0;
        endcase
    end

    assign CS = state;
    assign NS = state_nxt;
    assign OP = (state == S4);

`ifdef MOORE_DET_CNT_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            det_cnt <= '0;
        end else if ((state_nxt == S4) && (det_cnt != {CNT_W{1'b1}})) begin
            det_cnt <= det_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_moore_1010_seq_det_over.sv
// tb/tb_moore_1010_seq_det_over.sv - self-checking bench for moore_1010_seq_det_over
// Model tracks recent input history and derives state as the longest 1010 prefix suffix.
module tb_moore_1010_seq_det_over;

    logic       clk;
    logic       rst;
    logic       in_b;
    logic       op;
    logic [2:0] cs;
    logic [2:0] ns;
`ifdef MOORE_DET_CNT_EN
    logic [7:0] det_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int op_pulses = 0;

    logic       armed = 1'b0;
    logic [3:0] hist  = 4'b0000;
    int         hist_n = 0;
    int         exp_cnt = 0;

`ifdef MOORE_DET_CNT_EN
    moore_1010_seq_det_over #(.CNT_W(8)) dut (
        .Clk(clk), .Rst(rst), .In(in_b), .OP(op), .CS(cs), .NS(ns), .det_cnt(det_cnt)
    );
`else
    moore_1010_seq_det_over dut (
        .Clk(clk), .Rst(rst), .In(in_b), .OP(op), .CS(cs), .NS(ns)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Length of the longest suffix of the history (h[0] newest) that is a prefix of 1010.
    function automatic logic [2:0] match_len(input logic [3:0] h, input int n);
        if (n >= 4 && h == 4'b1010)      return 3'd4;
        if (n >= 3 && h[2:0] == 3'b101)  return 3'd3;
        if (n >= 2 && h[1:0] == 2'b10)   return 3'd2;
        if (n >= 1 && h[0] == 1'b1)      return 3'd1;
        return 3'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            armed   = 1'b1;
            hist    = 4'b0000;
            hist_n  = 0;
            exp_cnt = 0;
        end else if (armed) begin
            if (match_len({hist[2:0], in_b}, (hist_n < 4) ? hist_n + 1 : 4) == 3'd4 && exp_cnt < 255)
                exp_cnt++;
            hist   = {hist[2:0], in_b};
            hist_n = (hist_n < 4) ? hist_n + 1 : 4;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("cs_model", {29'd0, cs}, {29'd0, match_len(hist, hist_n)});
            check("op_model", {31'd0, op}, {31'd0, match_len(hist, hist_n) == 3'd4});
            check("ns_model", {29'd0, ns},
                  {29'd0, match_len({hist[2:0], in_b}, (hist_n < 4) ? hist_n + 1 : 4)});
`ifdef MOORE_DET_CNT_EN
            check("cnt_model", {24'd0, det_cnt}, exp_cnt);
`endif
            if (op === 1'b1) op_pulses++;
        end
    end

    task automatic step(input logic r, input logic b);
        rst  = r;
        in_b = b;
        @(posedge clk);
        #2;
    endtask

    logic [2:0] ovl_cs [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
    logic       ovl_in [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] nm_cs  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2};
    logic       nm_in  [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst  = 1'b1;
        in_b = 1'b0;

        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("reset_cs", {29'd0, cs}, 32'd0);
        check("reset_op", {31'd0, op}, 32'd0);
`ifdef MOORE_DET_CNT_EN
        check("reset_cnt", {24'd0, det_cnt}, 32'd0);
`endif

        op_pulses = 0;
        step(1'b0, 1'b1); check("basic_cs1", {29'd0, cs}, 32'd1);
        step(1'b0, 1'b0); check("basic_cs2", {29'd0, cs}, 32'd2);
        step(1'b0, 1'b1); check("basic_cs3", {29'd0, cs}, 32'd3);
        step(1'b0, 1'b0); check("basic_cs4", {29'd0, cs}, 32'd4);
        check("basic_op_hi", {31'd0, op}, 32'd1);
        step(1'b0, 1'b0);
        check("basic_op_lo", {31'd0, op}, 32'd0);
        check("basic_after0_cs", {29'd0, cs}, 32'd0);
        check("basic_pulses", op_pulses, 32'd1);

        step(1'b1, 1'b0);
        op_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, ovl_in[i]);
            check("ovl_cs", {29'd0, cs}, {29'd0, ovl_cs[i]});
        end
        step(1'b0, 1'b0);
        check("ovl_pulses", op_pulses, 32'd2);
`ifdef MOORE_DET_CNT_EN
        check("ovl_cnt", {24'd0, det_cnt}, 32'd2);
`endif

        step(1'b1, 1'b0);
        op_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, nm_in[i]);
            check("nm_cs", {29'd0, cs}, {29'd0, nm_cs[i]});
        end
        step(1'b0, 1'b0);
        check("nm_pulses", op_pulses, 32'd0);

        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("mid_cs_s3", {29'd0, cs}, 32'd3);
        in_b = 1'b1;
        #1 check("mid_ns_in1", {29'd0, ns}, 32'd1);
        in_b = 1'b0;
        #1 check("mid_ns_in0", {29'd0, ns}, 32'd4);
        check("mid_cs_hold", {29'd0, cs}, 32'd3);

        step(1'b1, 1'b0);
        check("rstmid_cs", {29'd0, cs}, 32'd0);
        check("rstmid_op", {31'd0, op}, 32'd0);
`ifdef MOORE_DET_CNT_EN
        check("rstmid_cnt", {24'd0, det_cnt}, 32'd0);
        step(1'b0, 1'b1);
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end
        check("sat_cnt", {24'd0, det_cnt}, 32'd255);
`endif

        step(1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
